// File: rtl/mux_n_1_rr.sv
// mux_n_1_rr: N-channel, WIDTH-bit registered multiplexer with valid/ready
// handshakes on every input channel and on the output.
// The grant is either the external select S (mode 0) or a round-robin pick
// among the valid channels (mode 1). The selected word lands in a one-deep
// output register.
//
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   in         N*WIDTH packed channel data; channel i is in[i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready; one-hot or zero
//   S          fixed-mode channel select
//   mode       0 = fixed select, 1 = round-robin
//   out        registered data word
//   out_valid  output register holds a word
//   out_ready  consumer takes the word this cycle
//   out_sel    index of the channel that supplied out
module mux_n_1_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     S,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel
);

  logic [N-1:0][WIDTH-1:0] in_arr;
  logic [SEL_W-1:0]        ptr;
  logic [SEL_W-1:0]        gnt;
  logic                    gnt_vld;
  logic                    load_en;

  assign in_arr  = in;
  assign load_en = !out_valid || out_ready;

  // Grant. Round-robin scans ptr+1, ptr+2, ... modulo N, so the channel
  // served last has lowest priority on the next pick.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    gnt     = ptr;
    gnt_vld = 1'b0;
    idx     = 0;
    idx_s   = '0;
    if (!mode) begin
      gnt = S;
      // S >= N is possible when N is not a power of two; it grants nothing.
      if (int'(S) < N) gnt_vld = in_valid[S];
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx   = (int'(ptr) + k) % N;
        idx_s = idx[SEL_W-1:0];
        if (!gnt_vld && in_valid[idx_s]) begin
          gnt_vld = 1'b1;
          gnt     = idx_s;
        end
      end
    end
  end

  // Ready is held low during reset so no producer sees a phantom transfer.
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = !rst && load_en && gnt_vld && (gnt == SEL_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= SEL_W'(N - 1);   // channel 0 gets first pick
    end else if (load_en) begin
      if (gnt_vld) begin
        out       <= in_arr[gnt];
        out_sel   <= gnt;
        out_valid <= 1'b1;
        // Fixed-mode transfers leave the round-robin position untouched.
        if (mode) ptr <= gnt;
      end else begin
        out_valid <= 1'b0;          // drained with nothing to refill
      end
    end
  end

endmodule

// File: tb/tb_mux_n_1_rr.sv
module tb_mux_n_1_rr;

  logic        clk;
  logic        rst;

  // N=4 instance
  logic [31:0] in_d;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  S;
  logic        mode;
  logic [7:0]  out_d;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  // N=3 instance (select out of range)
  logic [23:0] in3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  S3;
  logic        mode3;
  logic [7:0]  out3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_sel3;

  int tests;
  int fails;

  mux_n_1_rr #(.N(4), .WIDTH(8), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in(in_d), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .mode(mode), .out(out_d), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  mux_n_1_rr #(.N(3), .WIDTH(8), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in(in3), .in_valid(in_valid3), .in_ready(in_ready3),
    .S(S3), .mode(mode3), .out(out3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_sel(out_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // held in reset from time 0 with a valid channel present
    in_valid = 4'b0010;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_init_valid got %0b exp 0", out_valid); end
    tests++; if (out_d !== 8'h00) begin fails++; $display("FAIL rst_init_out got %h exp 00", out_d); end
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL rst_init_ready got %b exp 0000", in_ready); end
    step();
    rst = 1'b0;
    // fill with 0xA5 from channel 1 and hold (out_ready=0)
    mode = 1'b0; S = 2'd1; in_d = {8'h00, 8'h00, 8'hA5, 8'h00}; out_ready = 1'b0;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL rst_first_ready got %b exp 0010", in_ready); end
    step();
    tests++; if (out_d !== 8'hA5 || out_valid !== 1'b1 || out_sel !== 2'd1) begin
      fails++; $display("FAIL rst_fill got out=%h v=%0b sel=%0d exp A5 1 1", out_d, out_valid, out_sel); end
    // asynchronous reset mid-cycle while FULL
    #2;
    rst = 1'b1;
    #1;
    tests++; if (out_d !== 8'h00 || out_valid !== 1'b0 || out_sel !== 2'd0) begin
      fails++; $display("FAIL rst_async got out=%h v=%0b sel=%0d exp 00 0 0", out_d, out_valid, out_sel); end
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready_low got %b exp 0000", in_ready); end
    out_ready = 1'b1;
    step();
    tests++; if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rst_held got ready=%b v=%0b exp 0000 0", in_ready, out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; S = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    in_d = {8'h13, 8'h12, 8'h11, 8'h10};
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL fixed_ready got %b exp 0100", in_ready); end
    step();
    tests++; if (out_d !== 8'h12 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      fails++; $display("FAIL fixed_out got out=%h sel=%0d v=%0b exp 12 2 1", out_d, out_sel, out_valid); end
    in_valid = 4'b1011;
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL fixed_noval_ready got %b exp 0000", in_ready); end
    step();
    tests++; if (out_valid !== 1'b0 || out_d !== 8'h12) begin
      fails++; $display("FAIL fixed_drain got v=%0b out=%h exp 0 12", out_valid, out_d); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [5];
    logic [1:0] exp_b [4];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_b = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_d = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      step();
      tests++; if (out_sel !== exp_a[k] || out_valid !== 1'b1) begin
        fails++; $display("FAIL rr_all[%0d] got sel=%0d v=%0b exp %0d 1", k, out_sel, out_valid, exp_a[k]); end
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      tests++; if (out_sel !== exp_b[k] || out_valid !== 1'b1) begin
        fails++; $display("FAIL rr_1010[%0d] got sel=%0d v=%0b exp %0d 1", k, out_sel, out_valid, exp_b[k]); end
    end
    tests++; if (out_d !== 8'h13) begin fails++; $display("FAIL rr_data got %h exp 13", out_d); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; S = 2'd1; in_valid = 4'b1111; out_ready = 1'b0;
    in_d = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    for (int k = 0; k < 3; k++) begin
      tests++; if (out_d !== 8'h11 || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_hold[%0d] got out=%h v=%0b ready=%b exp 11 1 0000", k, out_d, out_valid, in_ready); end
      step();
    end
    S = 2'd2; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready got %b exp 0100", in_ready); end
    step();
    tests++; if (out_d !== 8'h12 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_drain_fill got out=%h sel=%0d v=%0b exp 12 2 1", out_d, out_sel, out_valid); end
  endtask

  task automatic test_range();
    mode3 = 1'b0; S3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    in3 = {8'h22, 8'h21, 8'h20};
    #1;
    tests++; if (in_ready3 !== 3'b000) begin fails++; $display("FAIL range_ready got %b exp 000", in_ready3); end
    step();
    step();
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL range_valid got %0b exp 0", out_valid3); end
    S3 = 2'd2;
    #1;
    tests++; if (in_ready3 !== 3'b100) begin fails++; $display("FAIL range_inrange_ready got %b exp 100", in_ready3); end
    step();
    tests++; if (out3 !== 8'h22 || out_valid3 !== 1'b1) begin
      fails++; $display("FAIL range_inrange_out got %h v=%0b exp 22 1", out3, out_valid3); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_d = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    step();
    tests++; if (out_sel !== 2'd1) begin fails++; $display("FAIL ms_ptr1 got %0d exp 1", out_sel); end
    mode = 1'b0; S = 2'd3;
    step();
    step();
    tests++; if (out_sel !== 2'd3 || out_d !== 8'h13) begin
      fails++; $display("FAIL ms_fixed got sel=%0d out=%h exp 3 13", out_sel, out_d); end
    mode = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL ms_rr_ready got %b exp 0100", in_ready); end
    step();
    tests++; if (out_sel !== 2'd2 || out_d !== 8'h12) begin
      fails++; $display("FAIL ms_rr_next got sel=%0d out=%h exp 2 12", out_sel, out_d); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1;
    in_d = '0; in_valid = '0; S = '0; mode = 1'b0; out_ready = 1'b0;
    in3 = '0; in_valid3 = '0; S3 = '0; mode3 = 1'b0; out_ready3 = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_range();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
